// File: rtl/rr_fifo_pkg.sv
// Shared definitions for the rr_merged_fifo storage slice.
//   DEFAULT_DEPTH      : default number of FIFO entries
//   DEFAULT_LANE_WIDTH : default width of one storage lane
//   lane_count()       : number of lanes needed to hold a word, ceil(width/lane_width)
package rr_fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 512;
  localparam int unsigned DEFAULT_LANE_WIDTH = 512;

  function automatic int unsigned lane_count(input int unsigned width,
                                             input int unsigned lane_width);
    return (width + lane_width - 1) / lane_width;
  endfunction

endpackage

// File: rtl/rr_fifo_lane_ram.sv
// One storage lane: simple dual-port RAM, one write port, one registered read port.
// Ports:
//   i_clk, i_rst        : clock, async active-high reset (read register only)
//   i_wr_en/addr/data   : write port
//   i_rd_en/addr        : read request; data appears on o_rd_data after the edge
//   o_rd_data           : registered read data, held while i_rd_en=0
module rr_fifo_lane_ram #(
  parameter int unsigned LANE_WIDTH = 512,
  parameter int unsigned DEPTH      = 512
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [LANE_WIDTH-1:0]    i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [LANE_WIDTH-1:0]    o_rd_data
);

  logic [LANE_WIDTH-1:0] r_mem [DEPTH];
  logic [LANE_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // The read register doubles as the FIFO's show-ahead output register, so it
  // is reset to give dout=0 out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rr_merged_fifo.sv
// Show-ahead (first-word-fall-through) FIFO for arbitrarily wide words, split
// across LANE_WIDTH storage lanes sharing one set of pointers.
// Ports:
//   clk, rst : clock, async active-high reset
//   din      : write data, accepted when wr_en=1 and full=0
//   wr_en    : write request
//   rd_en    : pop request, accepted when empty=0
//   dout     : head-of-queue data, valid while empty=0
//   full     : count == DEPTH
//   almfull  : count >= DEPTH - ALMFULL_THRESHOLD
//   empty    : no word is presented on dout
// A word written into an empty FIFO at edge N is presented after edge N+1
// (one prefetch stage through the registered RAM read).
module rr_merged_fifo
  import rr_fifo_pkg::*;
#(
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned DEPTH             = DEFAULT_DEPTH,
  parameter int unsigned ALMFULL_THRESHOLD = 100,
  parameter int unsigned LANE_WIDTH        = DEFAULT_LANE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             almfull,
  output logic             empty
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned NLANES = lane_count(WIDTH, LANE_WIDTH);
  localparam int unsigned ALM_I  = DEPTH - ALMFULL_THRESHOLD;

  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   ALM_LVL = ALM_I[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;    // words held, including the one on dout
  logic [AW:0]   r_ram_cnt;  // words in RAM not yet moved to the output register
  logic          r_valid;    // output register holds the head word

  logic          w_wr_acc, w_pop, w_fetch;
  logic [AW:0]   w_count_nxt, w_ram_cnt_nxt;
  logic [WIDTH-1:0] w_q;

  assign w_wr_acc = wr_en && !full;
  assign w_pop    = rd_en && r_valid;
  // Refill the output register whenever it is (or is about to become) free.
  // r_ram_cnt only counts words written at earlier edges, so the fetched
  // address never collides with a same-cycle write.
  assign w_fetch  = (r_ram_cnt != '0) && (!r_valid || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_pop)      w_count_nxt = r_count + CNT_ONE;
    else if (!w_wr_acc && w_pop) w_count_nxt = r_count - CNT_ONE;

    w_ram_cnt_nxt = r_ram_cnt;
    if (w_wr_acc && !w_fetch)      w_ram_cnt_nxt = r_ram_cnt + CNT_ONE;
    else if (!w_wr_acc && w_fetch) w_ram_cnt_nxt = r_ram_cnt - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ram_cnt <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_fetch)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count   <= w_count_nxt;
      r_ram_cnt <= w_ram_cnt_nxt;
      if (w_fetch)    r_valid <= 1'b1;
      else if (w_pop) r_valid <= 1'b0;
    end
  end

  // The top lane is sized to the live bits only; its padding would always
  // read back as zero.
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    localparam int unsigned LW = (i == NLANES - 1) ? (WIDTH - i * LANE_WIDTH) : LANE_WIDTH;
    rr_fifo_lane_ram #(
      .LANE_WIDTH (LW),
      .DEPTH      (DEPTH)
    ) u_ram (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (din[i*LANE_WIDTH +: LW]),
      .i_rd_en   (w_fetch),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_q[i*LANE_WIDTH +: LW])
    );
  end

  assign dout    = w_q;
  assign empty   = !r_valid;
  assign full    = (r_count == DEPTH_C);
  assign almfull = (r_count >= ALM_LVL);

endmodule

// File: tb/tb_rr_merged_fifo.sv
module tb_rr_merged_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] a_din, a_dout;
  logic       a_wr, a_rd, a_full, a_almfull, a_empty;

  logic [1099:0] b_din, b_dout;
  logic          b_wr, b_rd, b_full, b_almfull, b_empty;

  rr_merged_fifo #(.WIDTH(8), .DEPTH(16), .ALMFULL_THRESHOLD(4), .LANE_WIDTH(512)) dut_a (
    .clk(clk), .rst(rst), .din(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .dout(a_dout), .full(a_full), .almfull(a_almfull), .empty(a_empty)
  );

  rr_merged_fifo #(.WIDTH(1100), .DEPTH(16), .ALMFULL_THRESHOLD(4), .LANE_WIDTH(512)) dut_b (
    .clk(clk), .rst(rst), .din(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .dout(b_dout), .full(b_full), .almfull(b_almfull), .empty(b_empty)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: queue of words with the edge index at which each was written.
  // The head is visible once it was written at an edge before the latest one.
  logic [7:0]    qa_d[$];
  int            qa_e[$];
  logic [1099:0] qb_d[$];
  int            qb_e[$];
  int            edge_n = 0;

  function automatic bit a_vis();
    if (qa_d.size() == 0) return 1'b0;
    return qa_e[0] < edge_n;
  endfunction

  function automatic bit b_vis();
    if (qb_d.size() == 0) return 1'b0;
    return qb_e[0] < edge_n;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit ra, wa, rb, wb;
    if (rst) begin
      qa_d.delete(); qa_e.delete(); qb_d.delete(); qb_e.delete();
    end else begin
      ra = a_rd && a_vis();
      wa = a_wr && (qa_d.size() < 16);
      rb = b_rd && b_vis();
      wb = b_wr && (qb_d.size() < 16);
      if (ra) begin void'(qa_d.pop_front()); void'(qa_e.pop_front()); end
      if (wa) begin qa_d.push_back(a_din); qa_e.push_back(edge_n + 1); end
      if (rb) begin void'(qb_d.pop_front()); void'(qb_e.pop_front()); end
      if (wb) begin qb_d.push_back(b_din); qb_e.push_back(edge_n + 1); end
      edge_n++;
    end
  end

  always @(negedge clk) begin : compare
    logic [1099:0] bh;
    if (!rst) begin
      chk("m_a_empty",   a_empty,   !a_vis());
      chk("m_a_full",    a_full,    qa_d.size() == 16);
      chk("m_a_almfull", a_almfull, qa_d.size() >= 12);
      if (a_vis()) chk("m_a_dout", a_dout, qa_d[0]);
      chk("m_b_empty",   b_empty,   !b_vis());
      chk("m_b_full",    b_full,    qb_d.size() == 16);
      chk("m_b_almfull", b_almfull, qb_d.size() >= 12);
      if (b_vis()) begin
        bh = qb_d[0];
        chk("m_b_dout_l0", b_dout[511:0],     bh[511:0]);
        chk("m_b_dout_l1", b_dout[1023:512],  bh[1023:512]);
        chk("m_b_dout_l2", b_dout[1099:1024], bh[1099:1024]);
      end
    end
  end

  task automatic a_op(input logic w, input logic [7:0] d, input logic r);
    a_wr = w; a_din = d; a_rd = r;
    @(negedge clk); #2;
    a_wr = 1'b0; a_rd = 1'b0;
  endtask

  task automatic b_op(input logic w, input logic [1099:0] d, input logic r);
    b_wr = w; b_din = d; b_rd = r;
    @(negedge clk); #2;
    b_wr = 1'b0; b_rd = 1'b0;
  endtask

  function automatic logic [1099:0] wpat(input int k);
    logic [1099:0] w;
    logic [31:0]   k32;
    k32 = k;
    w = '0;
    w[511:0]     = {16{32'h1111_0000 + k32}};
    w[1023:512]  = {16{32'h2222_0000 + k32}};
    w[1099:1024] = {12'hABC, 32'h3333_4444, 32'h5555_0000 + k32};
    return w;
  endfunction

  initial begin : stim
    logic [1099:0] ew;
    rst = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Reset state
    chk("rst_a_empty", a_empty, 1'b1);
    chk("rst_a_full",  a_full,  1'b0);
    chk("rst_a_alm",   a_almfull, 1'b0);
    chk("rst_a_dout",  a_dout,  8'h00);
    chk("rst_b_empty", b_empty, 1'b1);
    chk("rst_b_dout",  b_dout[511:0], '0);

    // 1. Fill 0x01..0x10, overflow, drain in order
    for (int i = 1; i <= 16; i++) begin
      a_op(1'b1, 8'(i), 1'b0);
      chk("fill_alm",  a_almfull, i >= 12);
      chk("fill_full", a_full,    i == 16);
    end
    a_op(1'b1, 8'hFF, 1'b0);
    chk("ovf_full", a_full, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      chk("drain1_dout", a_dout, 8'(i));
      a_op(1'b0, 8'h00, 1'b1);
    end
    chk("drain1_empty", a_empty, 1'b1);
    chk("drain1_full",  a_full,  1'b0);

    // 2. Show-ahead with one prefetch stage
    a_op(1'b1, 8'hA5, 1'b0);
    chk("sa_empty_n", a_empty, 1'b1);
    a_op(1'b0, 8'h00, 1'b0);
    chk("sa_empty_n1", a_empty, 1'b0);
    chk("sa_dout",     a_dout,  8'hA5);
    a_op(1'b0, 8'h00, 1'b1);
    chk("sa_pop_empty", a_empty, 1'b1);

    // 3. Simultaneous read/write at count=8 across pointer wrap
    for (int i = 0; i < 8; i++) a_op(1'b1, 8'h20 + 8'(i), 1'b0);
    a_op(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("rw_dout", a_dout, 8'h20 + 8'(i));
      a_op(1'b1, 8'h28 + 8'(i), 1'b1);
      chk("rw_alm", a_almfull, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      chk("rw_drain", a_dout, 8'h34 + 8'(i));
      a_op(1'b0, 8'h00, 1'b1);
    end
    chk("rw_empty", a_empty, 1'b1);

    // 4. Full with read+write, then underflow
    for (int i = 0; i < 16; i++) a_op(1'b1, 8'h40 + 8'(i), 1'b0);
    a_op(1'b0, 8'h00, 1'b0);
    chk("fr_full", a_full, 1'b1);
    a_op(1'b1, 8'hEE, 1'b1);
    chk("fr_full_after", a_full,    1'b0);
    chk("fr_alm_after",  a_almfull, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      chk("fr_drain", a_dout, 8'h40 + 8'(i));
      a_op(1'b0, 8'h00, 1'b1);
    end
    chk("fr_empty", a_empty, 1'b1);
    chk("fr_dout_hold", a_dout, 8'h4F);
    a_op(1'b0, 8'h00, 1'b1);
    chk("udf_empty", a_empty, 1'b1);
    chk("udf_dout",  a_dout,  8'h4F);

    // 5. Wide words across three lanes
    for (int k = 0; k < 3; k++) b_op(1'b1, wpat(k), 1'b0);
    b_op(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ew = wpat(k);
      chk("wide_l0", b_dout[511:0],     ew[511:0]);
      chk("wide_l1", b_dout[1023:512],  ew[1023:512]);
      chk("wide_l2", b_dout[1099:1024], ew[1099:1024]);
      b_op(1'b0, '0, 1'b1);
    end
    chk("wide_empty", b_empty, 1'b1);

    // 6. Asynchronous reset mid-stream at count=5
    for (int i = 0; i < 5; i++) a_op(1'b1, 8'h60 + 8'(i), 1'b0);
    a_op(1'b0, 8'h00, 1'b0);
    chk("ar_pre_dout", a_dout, 8'h60);
    #1 rst = 1'b1;
    #1;
    chk("ar_empty", a_empty,   1'b1);
    chk("ar_full",  a_full,    1'b0);
    chk("ar_alm",   a_almfull, 1'b0);
    chk("ar_dout",  a_dout,    8'h00);
    @(negedge clk); #2 rst = 1'b0;
    a_op(1'b1, 8'h3C, 1'b0);
    a_op(1'b0, 8'h00, 1'b0);
    chk("ar_new_empty", a_empty, 1'b0);
    chk("ar_new_dout",  a_dout,  8'h3C);
    a_op(1'b0, 8'h00, 1'b1);
    chk("ar_new_pop", a_empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
